// File: rtl/ex_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit_if
// Purpose  : Request/response bundle between the EX stage and the mul/div unit.
// Revision : 1.0 - initial release
// ============================================================================
interface ex_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, flush, funct3, op_a, op_b,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, funct3, op_a, op_b,
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit
// Purpose  : Iterative RV32M multiply/divide, one bit per cycle on magnitudes.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input wire              clk,
    input wire              rst,
    ex_muldiv_unit_if.slave bus
);

    localparam int                 c_cnt_w    = $clog2(XLEN);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(XLEN - 1);
    localparam logic [XLEN-1:0]    c_int_min  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]    c_all_ones = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_funct3;
    logic [XLEN-1:0]    r_hi;
    logic [XLEN-1:0]    r_lo;
    logic [XLEN-1:0]    r_b;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [XLEN-1:0]    r_result;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_special;
    logic               w_finish;
    logic               w_a_signed;
    logic               w_b_signed;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [XLEN-1:0]    w_mag_a;
    logic [XLEN-1:0]    w_mag_b;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic [XLEN-1:0]    w_special_res;
    logic [XLEN:0]      w_mul_sum;
    logic [XLEN:0]      w_rem_sh;
    logic [XLEN-1:0]    w_diff;
    logic               w_rem_ge;
    logic [XLEN-1:0]    w_step_hi;
    logic [XLEN-1:0]    w_step_lo;
    logic [2*XLEN-1:0]  w_prod;
    logic [2*XLEN-1:0]  w_prod_fix;
    logic [XLEN-1:0]    w_quot;
    logic [XLEN-1:0]    w_rem;
    logic [XLEN-1:0]    w_final;

    // Operand signedness per RV32M opcode.
    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (bus.funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
            end
            3'b010:  w_a_signed = 1'b1;
            default: ;
        endcase
    end

    assign w_sign_a = w_a_signed & bus.op_a[XLEN-1];
    assign w_sign_b = w_b_signed & bus.op_b[XLEN-1];
    assign w_mag_a  = w_sign_a ? (~bus.op_a + 1'b1) : bus.op_a;
    assign w_mag_b  = w_sign_b ? (~bus.op_b + 1'b1) : bus.op_b;

    // Divide-by-zero and signed overflow resolve in one cycle.
    assign w_div_zero    = bus.funct3[2] & (bus.op_b == '0);
    assign w_div_ovf     = bus.funct3[2] & ~bus.funct3[0] &
                           (bus.op_a == c_int_min) & (bus.op_b == c_all_ones);
    assign w_special     = w_div_zero | w_div_ovf;
    assign w_special_res = w_div_zero ? (bus.funct3[1] ? bus.op_a : c_all_ones)
                                      : (bus.funct3[1] ? '0 : c_int_min);

    // Multiply: {hi,lo} holds accumulator:multiplier, shifting right.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

    // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
    assign w_rem_sh  = {r_hi, r_lo[XLEN-1]};
    assign w_rem_ge  = (w_rem_sh >= {1'b0, r_b});
    assign w_diff    = w_rem_sh[XLEN-1:0] - r_b;

    always_comb begin
        w_step_hi = r_hi;
        w_step_lo = r_lo;
        if (r_funct3[2]) begin
            w_step_hi = w_rem_ge ? w_diff : w_rem_sh[XLEN-1:0];
            w_step_lo = {r_lo[XLEN-2:0], w_rem_ge};
        end else begin
            w_step_hi = w_mul_sum[XLEN:1];
            w_step_lo = {w_mul_sum[0], r_lo[XLEN-1:1]};
        end
    end

    assign w_prod     = {w_step_hi, w_step_lo};
    assign w_prod_fix = r_neg_q ? (~w_prod + 1'b1) : w_prod;
    assign w_quot     = r_neg_q ? (~w_step_lo + 1'b1) : w_step_lo;
    assign w_rem      = r_neg_r ? (~w_step_hi + 1'b1) : w_step_hi;

    always_comb begin
        w_final = '0;
        case (r_funct3)
            3'b000:                 w_final = w_prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_final = w_quot;
            default:                w_final = w_rem;
        endcase
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    w_accept     = 1'b1;
                    w_state_next = w_special ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (bus.flush) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == c_cnt_last) begin
                    w_finish     = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == S_RUN);
            r_done  <= (w_state_next == S_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_funct3 <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_funct3 <= bus.funct3;
            r_hi     <= '0;
            r_lo     <= w_mag_a;
            r_b      <= w_mag_b;
            r_neg_q  <= w_sign_a ^ w_sign_b;
            r_neg_r  <= w_sign_a;
            if (w_special) begin
                r_result <= w_special_res;
            end
        end else if (r_state == S_RUN && !bus.flush) begin
            r_cnt <= r_cnt + 1'b1;
            r_hi  <= w_step_hi;
            r_lo  <= w_step_lo;
            if (w_finish) begin
                r_result <= w_final;
            end
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;

endmodule
`default_nettype wire
